// File: rtl/display_scheduler.sv
// Round-robin scheduler sharing one 2-digit 7-segment display among four requesters.
// Each grant shows its value for DWELL cycles, then the display goes dark for GAP cycles.
module display_scheduler #(
    parameter int DWELL = 4,
    parameter int GAP   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] val,
    output logic [3:0]  x,
    output logic        blank,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_GAP
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  dwellcnt, dwellcnt_nxt;
    logic [3:0]  gapcnt, gapcnt_nxt;
    logic [1:0]  last, last_nxt;
    logic [3:0]  x_nxt, gnt_nxt, done_nxt;
    logic        blank_nxt, busy_nxt;
    logic        found;
    logic [1:0]  winner;
    logic [1:0]  idx;

    // Round-robin search starting one past the last granted index.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // While a slot is active, last doubles as the index of the granted requester.
    always_comb begin
        state_nxt    = state;
        dwellcnt_nxt = dwellcnt;
        gapcnt_nxt   = gapcnt;
        last_nxt     = last;
        x_nxt        = x;
        gnt_nxt      = gnt;
        blank_nxt    = blank;
        done_nxt     = 4'b0000;

        case (state)
            S_IDLE: begin
                gnt_nxt   = 4'b0000;
                blank_nxt = 1'b1;
                if (found) begin
                    state_nxt    = S_SHOW;
                    dwellcnt_nxt = 8'd0;
                    last_nxt     = winner;
                    x_nxt        = val[{winner, 2'b00} +: 4];
                    gnt_nxt      = 4'b0001 << winner;
                    blank_nxt    = 1'b0;
                end
            end
            S_SHOW: begin
                if (!req[last]) begin
                    state_nxt  = S_GAP;
                    gapcnt_nxt = 4'd0;
                    gnt_nxt    = 4'b0000;
                    blank_nxt  = 1'b1;
                end else if (dwellcnt == 8'(DWELL - 1)) begin
                    state_nxt  = S_GAP;
                    gapcnt_nxt = 4'd0;
                    gnt_nxt    = 4'b0000;
                    blank_nxt  = 1'b1;
                    done_nxt   = 4'b0001 << last;
                end else begin
                    dwellcnt_nxt = dwellcnt + 8'd1;
                end
            end
            S_GAP: begin
                gnt_nxt   = 4'b0000;
                blank_nxt = 1'b1;
                if (gapcnt == 4'(GAP - 1)) begin
                    state_nxt  = S_IDLE;
                    gapcnt_nxt = 4'd0;
                end else begin
                    gapcnt_nxt = gapcnt + 4'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                gnt_nxt   = 4'b0000;
                blank_nxt = 1'b1;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            dwellcnt <= 8'd0;
            gapcnt   <= 4'd0;
            last     <= 2'd3;
            x        <= 4'd0;
            gnt      <= 4'b0000;
            blank    <= 1'b1;
            done     <= 4'b0000;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            dwellcnt <= dwellcnt_nxt;
            gapcnt   <= gapcnt_nxt;
            last     <= last_nxt;
            x        <= x_nxt;
            gnt      <= gnt_nxt;
            blank    <= blank_nxt;
            done     <= done_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler (DWELL=4, GAP=1): expected grants and
// done pulses are queued as stimulus is applied and compared when the DUT emits them.
module tb_display_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] val;
    logic [3:0]  x;
    logic        blank;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] grantq[$];
    logic [3:0] doneq[$];
    logic [3:0] prevgnt = 4'b0000;
    logic [3:0] prevx   = 4'd0;

    display_scheduler #(.DWELL(4), .GAP(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .val   (val),
        .x     (x),
        .blank (blank),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [15:0] v);
        req = r;
        val = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every new grant and every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
            checkOutput("blank_vs_gnt", 32'(blank), 32'(gnt == 4'b0000));
            if (gnt != 4'b0000 && prevgnt == 4'b0000) begin
                if (grantq.size() == 0)
                    checkOutput("grant_unexpected", {24'd0, gnt, x}, 32'd0);
                else
                    checkOutput("grant_seq", {24'd0, gnt, x}, {24'd0, grantq.pop_front()});
            end
            if (gnt != 4'b0000 && prevgnt == gnt)
                checkOutput("x_hold", 32'(x), 32'(prevx));
            if (done != 4'b0000) begin
                if (doneq.size() == 0)
                    checkOutput("done_unexpected", 32'(done), 32'd0);
                else
                    checkOutput("done_seq", 32'(done), 32'(doneq.pop_front()));
            end
        end
        prevgnt = gnt;
        prevx   = x;
    end

    initial begin
        rst = 1'b1;
        applyStimulus(4'b0000, 16'h0000);
        #3;
        checkOutput("rst_x", 32'(x), 32'd0);
        checkOutput("rst_blank", 32'(blank), 32'd1);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;

        // Single requester: 4-cycle dwell, done on leaving, 6-cycle regrant period, then abort
        applyStimulus(4'b0001, 16'h0009);
        grantq.push_back({4'b0001, 4'd9});
        grantq.push_back({4'b0001, 4'd9});
        doneq.push_back(4'b0001);
        tick();
        checkOutput("single_gnt", 32'(gnt), 32'h1);
        checkOutput("single_x", 32'(x), 32'h9);
        checkOutput("single_blank", 32'(blank), 32'd0);
        checkOutput("single_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("single_dwell", 32'(gnt), 32'h1);
        end
        tick();
        checkOutput("single_end_gnt", 32'(gnt), 32'h0);
        checkOutput("single_done", 32'(done), 32'h1);
        checkOutput("single_gap_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("single_done_pulse", 32'(done), 32'h0);
        checkOutput("single_idle_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("single_regrant", 32'(gnt), 32'h1);
        applyStimulus(4'b0000, 16'h0009);
        tick();
        checkOutput("single_abort_gnt", 32'(gnt), 32'h0);
        checkOutput("single_abort_done", 32'(done), 32'h0);
        tick();
        checkOutput("single_abort_idle", 32'(busy), 32'd0);

        // Abort: requester 2 drops in its second SHOW cycle
        applyStimulus(4'b0100, 16'h0600);
        grantq.push_back({4'b0100, 4'd6});
        tick();
        checkOutput("abort_gnt", 32'(gnt), 32'h4);
        tick();
        applyStimulus(4'b0000, 16'h0600);
        tick();
        checkOutput("abort_gnt_off", 32'(gnt), 32'h0);
        checkOutput("abort_blank", 32'(blank), 32'd1);
        checkOutput("abort_no_done", 32'(done), 32'h0);
        tick();
        checkOutput("abort_idle", 32'(busy), 32'd0);

        // Value capture: val slice changes during SHOW must not reach x
        applyStimulus(4'b0010, 16'h0050);
        grantq.push_back({4'b0010, 4'd5});
        doneq.push_back(4'b0010);
        tick();
        checkOutput("capture_gnt", 32'(gnt), 32'h2);
        applyStimulus(4'b0010, 16'h00E0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("capture_x", 32'(x), 32'h5);
        end
        tick();
        checkOutput("capture_done", 32'(done), 32'h2);
        applyStimulus(4'b0000, 16'h00E0);
        tick();
        tick();
        checkOutput("capture_idle", 32'(busy), 32'd0);

        // Reset mid-SHOW: asynchronous clear, no done, arbitration restarts at requester 0
        applyStimulus(4'b0001, 16'h0009);
        tick();
        checkOutput("midrst_pre_gnt", 32'(gnt), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_x", 32'(x), 32'd0);
        checkOutput("midrst_blank", 32'(blank), 32'd1);
        checkOutput("midrst_gnt", 32'(gnt), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        applyStimulus(4'b1111, 16'hFC73);
        grantq.push_back({4'b0001, 4'd3});
        grantq.push_back({4'b0010, 4'd7});
        grantq.push_back({4'b0100, 4'd12});
        grantq.push_back({4'b1000, 4'd15});
        grantq.push_back({4'b0001, 4'd3});
        doneq.push_back(4'b0001);
        doneq.push_back(4'b0010);
        doneq.push_back(4'b0100);
        doneq.push_back(4'b1000);
        #2;
        rst = 1'b0;

        // Round robin with all four requesting; fifth slot is aborted
        tick();
        checkOutput("rr_first_gnt", 32'(gnt), 32'h1);
        repeat (24) @(posedge clk);
        #1;
        checkOutput("rr_fifth_gnt", 32'(gnt), 32'h1);
        applyStimulus(4'b0000, 16'hFC73);
        repeat (3) tick();
        checkOutput("rr_idle", 32'(busy), 32'd0);

        // Late contender: requester 3 arrives mid-slot and is served before requester 0 again
        applyStimulus(4'b0001, 16'hFC73);
        grantq.push_back({4'b0001, 4'd3});
        grantq.push_back({4'b1000, 4'd15});
        grantq.push_back({4'b0001, 4'd3});
        doneq.push_back(4'b0001);
        doneq.push_back(4'b1000);
        tick();
        checkOutput("late_first_gnt", 32'(gnt), 32'h1);
        tick();
        applyStimulus(4'b1001, 16'hFC73);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("late_second_gnt", 32'(gnt), 32'h8);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("late_third_gnt", 32'(gnt), 32'h1);
        applyStimulus(4'b0000, 16'hFC73);
        repeat (3) tick();
        checkOutput("late_idle", 32'(busy), 32'd0);

        checkOutput("grantq_empty", 32'(grantq.size()), 32'd0);
        checkOutput("doneq_empty", 32'(doneq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter DWELL, default 4, number of clock cycles a granted value SHALL stay on the display (legal 2..255).
REQ-002 Parameter GAP, default 1, number of blank cycles SHALL follow every display slot (legal 1..15).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req  input  4  per-requester request; bit i asserted while requester i wants the display.
REQ-006 val  input  16  requester values; val[4i+3:4i] is the 4-bit value of requester i.
REQ-007 x  output  4  value driven to the shared two-digit decimal 7-segment decoder.
REQ-008 blank  output  1  high when the display shall be dark; the top level gates decoder outputs with it.
REQ-009 gnt  output  4  one-hot grant; at most one bit high.
REQ-010 done  output  4  one-cycle pulse on bit i when requester i completes a full DWELL slot.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, SHOW and GAP; all outputs registered.
REQ-013 IDLE: any req bit high at a rising edge -> SHOW on that edge, gnt set to the winner, x loaded from the winner's val slice, blank cleared (grant latency 1 cycle from req).
REQ-014 Winner SHALL be chosen round-robin: search starts at index (last+1) mod 4 and wraps; last = index of previous grant.
REQ-015 x SHALL be captured once at grant; val changes during SHOW SHALL NOT affect x.
REQ-016 SHOW: 8-bit dwell counter starts at 0 on entry and increments each cycle; gnt held, blank low.
REQ-017 SHOW with counter = DWELL-1 and req of granted bit still high -> GAP; done bit of that requester high for exactly that one transition cycle (coincident with gnt falling).
REQ-018 SHOW with granted req bit low at an edge -> abort: GAP immediately, no done pulse; last still updated to the aborted index.
REQ-019 Other req bits changing during SHOW SHALL have no effect until the next IDLE arbitration.
REQ-020 GAP: gnt = 0, blank = 1, x holds previous value; gap counter runs GAP cycles, then -> IDLE.
REQ-021 IDLE: gnt = 0, blank = 1, busy = 0.
REQ-022 A requester holding req continuously SHALL be re-granted only after every other active requester has been served once.
REQ-023 Slot length (grant to grant for back-to-back requests) SHALL be DWELL + GAP + 1 cycles.
REQ-024 done and gnt SHALL never have more than one bit high; done bit i only while leaving a slot granted to i.

Reset
REQ-025 rst high SHALL immediately force: state IDLE, x = 0, blank = 1, gnt = 0, done = 0, busy = 0, dwell and gap counters = 0, last = 3 (requester 0 wins first).
REQ-026 rst asserted mid-SHOW SHALL abort the slot with no done pulse; after release, arbitration restarts from requester 0.
REQ-027 First arbitration SHALL occur on the first rising edge after rst deasserts.

Verification (DWELL=4, GAP=1)
REQ-028 Reset check: rst pulse mid-operation -> x=0, blank=1, gnt=0, done=0, busy=0 asynchronously, before next clk edge.
REQ-029 Single requester: req=0001, val[3:0]=9 -> next edge gnt=0001, x=9, blank=0 for 4 cycles; done=0001 on 4th; 1 blank cycle; re-grant follows (6-cycle period).
REQ-030 Round-robin: req=1111 held, val slices 3,7,12,15 -> grants 0001,0010,0100,1000,0001 in order with x=3,7,12,15,3.
REQ-031 Abort: req=0100 granted, drop req bit 2 in 2nd SHOW cycle -> next edge gnt=0, blank=1, no done; IDLE after 1 gap cycle.
REQ-032 Value capture: grant requester 1 with val=5, change val slice to 14 during SHOW -> x stays 5 for whole slot.
REQ-033 Late contender: req=0001 granted, raise req bit 3 mid-slot -> requester 3 granted next, then requester 0.
